control_pulsadores: RTL and testbench

Front-end controller for the push-button-driven counters. It debounces two raw buttons (`btn_up`, `btn_dn`) and grants the shared counter step interface to one of them at a time. Simultaneous presses are resolved round-robin. Each accepted press produces a single-cycle step pulse, optionally followed by auto-repeat pulses while the button is held. The `step_up`/`step_dn` outputs drive the counters' increment/decrement inputs directly, so the counters need no edge detection of their own.

---
 rtl/control_pulsadores.sv | 147 ++++++++++++++
 tb/tb_control_pulsadores.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pulsadores.sv
// control_pulsadores: synchronizes and debounces the up/down push buttons and
// grants the shared counter step interface to one button at a time. Each
// accepted press gives one step pulse, optionally followed by auto-repeat
// pulses while the owning button stays held.
module control_pulsadores #(
  parameter int DEB_CYCLES = 4,
  parameter int REP_DELAY  = 16,
  parameter int REP_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       en_repeat,
  output logic       step_up,
  output logic       step_dn,
  output logic       db_up,
  output logic       db_dn,
  output logic [1:0] owner
);

  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
  localparam logic [15:0] DLY_LAST = 16'(REP_DELAY - 1);
  localparam logic [15:0] PER_LAST = 16'(REP_PERIOD - 1);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_UP   = 2'b01;
  localparam logic [1:0] OWN_DN   = 2'b10;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  db;
  logic [1:0]  db_prev;
  logic [1:0]  press;
  logic [15:0] deb_cnt [2];

  state_t      state;
  logic [15:0] rep_cnt;
  logic [15:0] rep_last;
  logic        last_grant;
  logic        held;

  // Two-flop synchronizer for both raw button pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_dn, btn_up};
      sync2 <= sync1;
    end
  end

  // Debouncers: the debounced state flips only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      db         <= '0;
      db_prev    <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      db_prev <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          db[i]      <= ~db[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign db_up = db[0];
  assign db_dn = db[1];
  assign press = db & ~db_prev;

  // Debounced level of whichever button currently owns the grant.
  always_comb begin
    held = 1'b0;
    case (owner)
      OWN_UP:  held = db[0];
      OWN_DN:  held = db[1];
      default: held = 1'b0;
    endcase
  end

  assign rep_last = (state == REPEAT) ? PER_LAST : DLY_LAST;

  // Grant/repeat FSM; release is tested before the repeat threshold so it always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      rep_cnt    <= '0;
      last_grant <= 1'b1;
    end else begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
      case (state)
        IDLE: begin
          rep_cnt <= '0;
          if (press[0] && (!press[1] || last_grant)) begin
            owner      <= OWN_UP;
            last_grant <= 1'b0;
            step_up    <= 1'b1;
            state      <= DELAY;
          end else if (press[1]) begin
            owner      <= OWN_DN;
            last_grant <= 1'b1;
            step_dn    <= 1'b1;
            state      <= DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!held) begin
            state   <= IDLE;
            owner   <= OWN_NONE;
            rep_cnt <= '0;
          end else if (!en_repeat) begin
            rep_cnt <= '0;
          end else if (rep_cnt == rep_last) begin
            step_up <= (owner == OWN_UP);
            step_dn <= (owner == OWN_DN);
            rep_cnt <= '0;
            state   <= REPEAT;
          end else begin
            rep_cnt <= rep_cnt + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          owner   <= OWN_NONE;
          rep_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_pulsadores.sv
// tb_control_pulsadores: scenario tasks for the button front-end. Expected
// step pulses are queued with their cycle numbers when stimulus is driven;
// a monitor records observed pulses and each scenario compares the queues.
module tb_control_pulsadores;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       en_repeat = 1'b0;
  logic       step_up;
  logic       step_dn;
  logic       db_up;
  logic       db_dn;
  logic [1:0] owner;

  typedef struct {
    int cyc;
    bit dir;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     both_high = 0;

  // Raw pin to registered pulse: 2 synchronizer edges + DEB_CYCLES + 1.
  localparam int LAT = 7;

  control_pulsadores dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_dn(btn_dn),
    .en_repeat(en_repeat),
    .step_up(step_up),
    .step_dn(step_dn),
    .db_up(db_up),
    .db_dn(db_dn),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // Cycle number = count of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every observed step pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (step_up) obs_q.push_back('{cyc: cyc, dir: 1'b0});
    if (step_dn) obs_q.push_back('{cyc: cyc, dir: 1'b1});
    if (step_up && step_dn) both_high++;
  end

  task automatic step_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input bit d);
    exp_q.push_back('{cyc: c, dir: d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    en_repeat = 1'b0;
    step_to(cyc + 3);
    rst = 1'b0;
    step_to(cyc + 12);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    step_to(cyc + 3);
    n_checks++;
    if (step_up !== 1'b0 || step_dn !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_steps: got up=%b dn=%b, required 0 0", step_up, step_dn);
    end
    n_checks++;
    if (db_up !== 1'b0 || db_dn !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_db: got up=%b dn=%b, required 0 0", db_up, db_dn);
    end
    n_checks++;
    if (owner !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_owner: got %b, required 00", owner);
    end
    rst = 1'b0;
    step_to(cyc + 12);
  endtask

  task automatic test_bounce();
    int k;
    pulse_t e, o;
    do_reset();
    k = cyc;
    btn_up = 1'b1;
    step_to(k + 3);
    btn_up = 1'b0;
    step_to(k + 4);
    btn_up = 1'b1;
    push_exp(k + 4 + LAT, 1'b0);
    step_to(k + 9);
    n_checks++;
    if (db_up !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bounce_db_early: got %b, required 0", db_up);
    end
    step_to(k + 10);
    n_checks++;
    if (db_up !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bounce_db_set: got %b, required 1", db_up);
    end
    step_to(k + 12);
    n_checks++;
    if (owner !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL bounce_owner: got %b, required 01", owner);
    end
    step_to(k + 30);
    btn_up = 1'b0;
    step_to(k + 36);
    n_checks++;
    if (db_up !== 1'b0 || owner !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL release_edge: got db=%b owner=%b, required db=0 owner=01", db_up, owner);
    end
    step_to(k + 37);
    n_checks++;
    if (owner !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL release_owner: got %b, required 00", owner);
    end
    step_to(k + 50);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); n_fail++;
        $display("[TB] FAIL bounce_pulse: got no pulse, required dir %0d at cycle %0d", e.dir, e.cyc);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); n_fail++;
        $display("[TB] FAIL bounce_pulse: got dir %0d at cycle %0d, required no pulse", o.dir, o.cyc);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.dir !== e.dir) begin
          n_fail++;
          $display("[TB] FAIL bounce_pulse: got dir %0d at cycle %0d, required dir %0d at cycle %0d", o.dir, o.cyc, e.dir, e.cyc);
        end
      end
    end
  endtask

  task automatic test_hold_repeat();
    int k, p;
    pulse_t e, o;
    do_reset();
    en_repeat = 1'b1;
    k = cyc;
    btn_dn = 1'b1;
    p = k + LAT;
    push_exp(p, 1'b1);
    for (int t = p + 16; t <= p + 56; t += 8) push_exp(t, 1'b1);
    step_to(p + 54);
    btn_dn = 1'b0;
    step_to(p + 90);
    en_repeat = 1'b0;
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); n_fail++;
        $display("[TB] FAIL repeat_pulse: got no pulse, required dir %0d at cycle %0d", e.dir, e.cyc);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); n_fail++;
        $display("[TB] FAIL repeat_pulse: got dir %0d at cycle %0d, required no pulse", o.dir, o.cyc);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.dir !== e.dir) begin
          n_fail++;
          $display("[TB] FAIL repeat_pulse: got dir %0d at cycle %0d, required dir %0d at cycle %0d", o.dir, o.cyc, e.dir, e.cyc);
        end
      end
    end
  endtask

  task automatic test_tie();
    int k;
    pulse_t e, o;
    do_reset();
    k = cyc;
    btn_up = 1'b1;
    btn_dn = 1'b1;
    push_exp(k + LAT, 1'b0);
    step_to(k + 9);
    n_checks++;
    if (owner !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL tie1_owner: got %b, required 01", owner);
    end
    step_to(k + 20);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    step_to(k + 40);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    push_exp(k + 40 + LAT, 1'b1);
    step_to(k + 49);
    n_checks++;
    if (owner !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL tie2_owner: got %b, required 10", owner);
    end
    step_to(k + 60);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    step_to(k + 80);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); n_fail++;
        $display("[TB] FAIL tie_pulse: got no pulse, required dir %0d at cycle %0d", e.dir, e.cyc);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); n_fail++;
        $display("[TB] FAIL tie_pulse: got dir %0d at cycle %0d, required no pulse", o.dir, o.cyc);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.dir !== e.dir) begin
          n_fail++;
          $display("[TB] FAIL tie_pulse: got dir %0d at cycle %0d, required dir %0d at cycle %0d", o.dir, o.cyc, e.dir, e.cyc);
        end
      end
    end
  endtask

  task automatic test_non_owner();
    int k;
    pulse_t e, o;
    do_reset();
    k = cyc;
    btn_up = 1'b1;
    push_exp(k + LAT, 1'b0);
    step_to(k + 15);
    btn_dn = 1'b1;
    step_to(k + 25);
    n_checks++;
    if (owner !== 2'b01 || db_dn !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL nonowner_hold: got owner=%b db_dn=%b, required 01 1", owner, db_dn);
    end
    step_to(k + 30);
    btn_up = 1'b0;
    step_to(k + 45);
    n_checks++;
    if (owner !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL nonowner_after_release: got owner %b, required 00", owner);
    end
    step_to(k + 60);
    btn_dn = 1'b0;
    step_to(k + 75);
    btn_dn = 1'b1;
    push_exp(k + 75 + LAT, 1'b1);
    step_to(k + 83);
    n_checks++;
    if (owner !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL nonowner_repress_owner: got %b, required 10", owner);
    end
    step_to(k + 90);
    btn_dn = 1'b0;
    step_to(k + 105);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); n_fail++;
        $display("[TB] FAIL nonowner_pulse: got no pulse, required dir %0d at cycle %0d", e.dir, e.cyc);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); n_fail++;
        $display("[TB] FAIL nonowner_pulse: got dir %0d at cycle %0d, required no pulse", o.dir, o.cyc);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.dir !== e.dir) begin
          n_fail++;
          $display("[TB] FAIL nonowner_pulse: got dir %0d at cycle %0d, required dir %0d at cycle %0d", o.dir, o.cyc, e.dir, e.cyc);
        end
      end
    end
  endtask

  task automatic test_repeat_disabled();
    int k;
    pulse_t e, o;
    do_reset();
    k = cyc;
    btn_up = 1'b1;
    push_exp(k + LAT, 1'b0);
    push_exp(k + 66, 1'b0);
    push_exp(k + 74, 1'b0);
    push_exp(k + 96, 1'b0);
    push_exp(k + 104, 1'b0);
    step_to(k + 50);
    en_repeat = 1'b1;
    step_to(k + 78);
    en_repeat = 1'b0;
    step_to(k + 88);
    en_repeat = 1'b1;
    step_to(k + 100);
    btn_up = 1'b0;
    step_to(k + 125);
    en_repeat = 1'b0;
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); n_fail++;
        $display("[TB] FAIL norepeat_pulse: got no pulse, required dir %0d at cycle %0d", e.dir, e.cyc);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); n_fail++;
        $display("[TB] FAIL norepeat_pulse: got dir %0d at cycle %0d, required no pulse", o.dir, o.cyc);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.dir !== e.dir) begin
          n_fail++;
          $display("[TB] FAIL norepeat_pulse: got dir %0d at cycle %0d, required dir %0d at cycle %0d", o.dir, o.cyc, e.dir, e.cyc);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int k, p;
    pulse_t e, o;
    do_reset();
    en_repeat = 1'b1;
    k = cyc;
    btn_up = 1'b1;
    p = k + LAT;
    push_exp(p, 1'b0);
    step_to(p + 10);
    rst = 1'b1;
    step_to(p + 11);
    n_checks++;
    if (step_up !== 1'b0 || owner !== 2'b00 || db_up !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got step=%b owner=%b db=%b, required 0 00 0", step_up, owner, db_up);
    end
    step_to(p + 13);
    rst = 1'b0;
    push_exp(p + 13 + LAT, 1'b0);
    step_to(p + 25);
    btn_up = 1'b0;
    step_to(p + 45);
    en_repeat = 1'b0;
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_checks++;
      if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); n_fail++;
        $display("[TB] FAIL midreset_pulse: got no pulse, required dir %0d at cycle %0d", e.dir, e.cyc);
      end else if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); n_fail++;
        $display("[TB] FAIL midreset_pulse: got dir %0d at cycle %0d, required no pulse", o.dir, o.cyc);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.dir !== e.dir) begin
          n_fail++;
          $display("[TB] FAIL midreset_pulse: got dir %0d at cycle %0d, required dir %0d at cycle %0d", o.dir, o.cyc, e.dir, e.cyc);
        end
      end
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_high !== 0) begin
      n_fail++;
      $display("[TB] FAIL exclusive_steps: got %0d cycles with both steps high, required 0", both_high);
    end
  endtask

  // Scenario sequence.
  initial begin
    @(negedge clk);
    $display("[TB] starting control_pulsadores scenarios");
    test_reset();
    test_bounce();
    test_hold_repeat();
    test_tie();
    test_non_owner();
    test_repeat_disabled();
    test_reset_mid_hold();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
